duplex_mailbox: RTL and testbench
=================================

// Module: duplex_mailbox
//
// PURPOSE
// - Bidirectional mailbox between two agents (A = CPU side, B = peripheral side) on one clock.
// - Each direction has its own DW-bit FIFO of DEPTH entries, with show-ahead read,
//   back-pressure (wait), occupancy counts and sticky overflow flags.
// - Successor to the single-register 8-bit exchange: it adds width/depth parameters,
//   buffering, and defined full/empty/overflow behaviour.
//
// PARAMETERS
// - DW     8   data width of both directions, >= 1
// - DEPTH  4   entries per direction FIFO, >= 2 (any integer; power of 2 not required)
// - CW     derived, $clog2(DEPTH+1): count width
//
// PORTS
// - clk        in   1   single clock, all state on posedge
// - rst        in   1   asynchronous, active-low reset
// - a_wr       in   1   A pushes a_wdata into the A->B FIFO
// - a_wdata    in   DW  data from A
// - a_wait     out  1   A->B FIFO full
// - a_rd       in   1   A pops the B->A FIFO head
// - a_rdata    out  DW  B->A FIFO head; 0 when empty
// - a_rvalid   out  1   B->A FIFO not empty
// - a_ovf      out  1   sticky: an A write was dropped
// - a_ovf_clr  in   1   clears a_ovf
// - b_wr/b_wdata/b_wait/b_rd/b_rdata/b_rvalid/b_ovf/b_ovf_clr
//                       mirror of the A ports for B; B writes the B->A FIFO, reads the A->B FIFO
// - a2b_cnt    out  CW  A->B occupancy, 0..DEPTH
// - b2a_cnt    out  CW  B->A occupancy, 0..DEPTH
//
// BEHAVIOUR
// - Reset (rst=0, asynchronous):
//   - pointers, counts, a_ovf and b_ovf = 0
//   - wait = 0, rvalid = 0, rdata = 0
//   - storage array is not reset
// - Each FIFO has wr_ptr, rd_ptr and cnt registers.
//   - Each pointer wraps from DEPTH-1 to 0.
//   - full = (cnt == DEPTH); empty = (cnt == 0).
//   - wait = full and rvalid = !empty, both decoded from registered cnt.
//   - rdata = mem[rd_ptr] gated to 0 when empty.
// - Write accepted iff wr && (!full || rd_accepted). Read accepted iff rd && !empty.
//   - Accepted write: mem[wr_ptr] <= wdata, wr_ptr++.
//   - Accepted read: rd_ptr++.
//   - cnt: +1 for write only, -1 for read only, unchanged for both or neither.
// - Latency: a write accepted at edge N makes the far side's rvalid = 1 and rdata valid
//   from edge N onward (one cycle, write to visible).
// - Full + simultaneous rd and wr: both accepted; cnt stays DEPTH; wait stays 1.
// - Full + wr without rd: write dropped; storage and pointers untouched; ovf <= 1 at that edge.
// - Empty + rd: ignored, no pointer change, no error flag.
// - Empty + rd + wr: read ignored, write accepted, cnt becomes 1.
// - ovf flags:
//   - set on a dropped write, clear on ovf_clr.
//   - set wins over clear in the same cycle.
//   - flags hold until cleared or reset.
// - The two directions are fully independent; simultaneous activity on all four strobes
//   is legal.
// - Reset mid-operation discards all contents; outputs go to reset values immediately.
// - No X on outputs after reset, including rdata of never-written slots (gated by empty).
//
// TESTING
// - Reset, then idle: all outputs 0, a2b_cnt = b2a_cnt = 0; a_rd pulse when empty -> no change.
// - A writes 0x11,0x22,0x33,0x44 (DEPTH=4):
//   - b_rvalid rises the cycle after the first write, b_rdata = 0x11.
//   - a_wait = 1 after the 4th write, a2b_cnt = 4.
//   - B pops 4 -> data in order, then b_rvalid = 0, b_rdata = 0.
// - Full A->B, A writes 0x55 without b_rd:
//   - a_ovf = 1, a2b_cnt stays 4, contents unchanged.
//   - a_ovf_clr together with another dropped write -> a_ovf stays 1; next a_ovf_clr alone -> 0.
// - Full A->B, a_wr=0x66 and b_rd in the same cycle:
//   - b_rdata advances, cnt stays 4, no ovf.
//   - After draining, last word = 0x66; pointers wrap correctly over 3 full passes.
// - Both directions at once: A streams 0x01.. while B streams 0x81.., each side reading
//   every cycle -> no loss, counts stay <= 1, each data order preserved.
// - Reset asserted with both FIFOs half full -> counts, flags, rvalid and rdata = 0 at once;
//   first write after release reads back correctly.

Source files
------------

// File: rtl/duplex_mailbox.sv
// Bidirectional mailbox: two independent show-ahead FIFOs with back-pressure,
// occupancy counts and sticky overflow flags, all on a single clock.

// One direction of the mailbox: show-ahead FIFO with drop-on-full and sticky overflow.
module mailbox_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr,
    input  logic [DW-1:0]                  wdata,
    input  logic                           rd,
    output logic [DW-1:0]                  rdata,
    output logic                           rvalid,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     cnt,
    output logic                           ovf,
    input  logic                           ovf_clr
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          rd_ok;
    logic          wr_ok;
    logic          drop;

    // Status decode and transfer qualification from the registered count.
    always_comb begin
        full   = (cnt == CW'(DEPTH));
        empty  = (cnt == '0);
        rvalid = !empty;
        rd_ok  = rd && !empty;
        wr_ok  = wr && (!full || rd_ok);
        drop   = wr && !wr_ok;
        rdata  = empty ? '0 : mem[rd_ptr];
    end

    // Pointers, occupancy and sticky overflow; a drop in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage is not reset; reads of unwritten slots are masked while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

// Top: A writes the A->B FIFO and reads the B->A FIFO; B does the mirror.
module duplex_mailbox #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           a_wr,
    input  logic [DW-1:0]                  a_wdata,
    output logic                           a_wait,
    input  logic                           a_rd,
    output logic [DW-1:0]                  a_rdata,
    output logic                           a_rvalid,
    output logic                           a_ovf,
    input  logic                           a_ovf_clr,
    input  logic                           b_wr,
    input  logic [DW-1:0]                  b_wdata,
    output logic                           b_wait,
    input  logic                           b_rd,
    output logic [DW-1:0]                  b_rdata,
    output logic                           b_rvalid,
    output logic                           b_ovf,
    input  logic                           b_ovf_clr,
    output logic [$clog2(DEPTH+1)-1:0]     a2b_cnt,
    output logic [$clog2(DEPTH+1)-1:0]     b2a_cnt
);
    mailbox_fifo #(.DW(DW), .DEPTH(DEPTH)) u_a2b (
        .clk     (clk),
        .rst     (rst),
        .wr      (a_wr),
        .wdata   (a_wdata),
        .rd      (b_rd),
        .rdata   (b_rdata),
        .rvalid  (b_rvalid),
        .full    (a_wait),
        .cnt     (a2b_cnt),
        .ovf     (a_ovf),
        .ovf_clr (a_ovf_clr)
    );

    mailbox_fifo #(.DW(DW), .DEPTH(DEPTH)) u_b2a (
        .clk     (clk),
        .rst     (rst),
        .wr      (b_wr),
        .wdata   (b_wdata),
        .rd      (a_rd),
        .rdata   (a_rdata),
        .rvalid  (a_rvalid),
        .full    (b_wait),
        .cnt     (b2a_cnt),
        .ovf     (b_ovf),
        .ovf_clr (b_ovf_clr)
    );
endmodule

// File: tb/tb_duplex_mailbox.sv
// Directed bench for duplex_mailbox (DW=8, DEPTH=4).
module tb_duplex_mailbox;
    logic       clk;
    logic       rst;
    logic       a_wr, a_rd, a_ovf_clr, a_wait, a_rvalid, a_ovf;
    logic       b_wr, b_rd, b_ovf_clr, b_wait, b_rvalid, b_ovf;
    logic [7:0] a_wdata, a_rdata, b_wdata, b_rdata;
    logic [2:0] a2b_cnt, b2a_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q[$];

    duplex_mailbox #(.DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_wr(a_wr), .a_wdata(a_wdata), .a_wait(a_wait), .a_rd(a_rd),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_ovf(a_ovf), .a_ovf_clr(a_ovf_clr),
        .b_wr(b_wr), .b_wdata(b_wdata), .b_wait(b_wait), .b_rd(b_rd),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_ovf(b_ovf), .b_ovf_clr(b_ovf_clr),
        .a2b_cnt(a2b_cnt), .b2a_cnt(b2a_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        rst = 1'b0;
        a_wr = 0; a_rd = 0; a_ovf_clr = 0; a_wdata = '0;
        b_wr = 0; b_rd = 0; b_ovf_clr = 0; b_wdata = '0;
        #23;
        outs = {a_wait, a_rvalid, a_ovf, b_wait, b_rvalid, b_ovf, a2b_cnt, b2a_cnt, a_rdata[3:0], b_rdata[3:0]};
        n_cmp++;
        if (outs !== 24'h0 || a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            n_err++; $display("FAIL reset_outputs: got %h a_rdata %h b_rdata %h expected all 0", outs, a_rdata, b_rdata);
        end
        rst = 1'b1;
        tick();
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        n_cmp++;
        if ({a_rvalid, b2a_cnt, a_rdata} !== 12'h000) begin
            n_err++; $display("FAIL empty_rd: got rvalid %b cnt %0d rdata %h expected 0 0 00", a_rvalid, b2a_cnt, a_rdata);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_wdata = vals[i];
            tick();
            if (i == 0) begin
                n_cmp++;
                if (b_rvalid !== 1'b1 || b_rdata !== 8'h11) begin
                    n_err++; $display("FAIL first_write: got rvalid %b rdata %h expected 1 11", b_rvalid, b_rdata);
                end
            end
            n_cmp++;
            if (a2b_cnt !== 3'(i + 1)) begin
                n_err++; $display("FAIL fill_cnt%0d: got %0d expected %0d", i, a2b_cnt, i + 1);
            end
        end
        a_wr = 1'b0;
        n_cmp++;
        if (a_wait !== 1'b1) begin
            n_err++; $display("FAIL full_wait: got %b expected 1", a_wait);
        end
    endtask

    task automatic test_overflow();
        a_wr = 1'b1; a_wdata = 8'h55;
        tick();
        a_wr = 1'b0;
        n_cmp++;
        if (a_ovf !== 1'b1 || a2b_cnt !== 3'd4 || b_rdata !== 8'h11) begin
            n_err++; $display("FAIL ovf_set: got ovf %b cnt %0d head %h expected 1 4 11", a_ovf, a2b_cnt, b_rdata);
        end
        a_wr = 1'b1; a_ovf_clr = 1'b1;
        tick();
        a_wr = 1'b0;
        n_cmp++;
        if (a_ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_set_wins: got %b expected 1", a_ovf);
        end
        tick();
        a_ovf_clr = 1'b0;
        n_cmp++;
        if (a_ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr: got %b expected 0", a_ovf);
        end
    endtask

    task automatic test_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        b_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (b_rdata !== vals[i]) begin
                n_err++; $display("FAIL drain%0d: got %h expected %h", i, b_rdata, vals[i]);
            end
            tick();
        end
        b_rd = 1'b0;
        n_cmp++;
        if (b_rvalid !== 1'b0 || b_rdata !== 8'h00 || a2b_cnt !== 3'd0 || a_wait !== 1'b0) begin
            n_err++; $display("FAIL drained: got rvalid %b rdata %h cnt %0d wait %b expected 0 00 0 0", b_rvalid, b_rdata, a2b_cnt, a_wait);
        end
    endtask

    task automatic test_full_rw();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                a_wr = 1'b1; a_wdata = 8'(p * 16 + i + 1);
                q.push_back(a_wdata);
                tick();
            end
            a_wdata = 8'(8'h66 + p); b_rd = 1'b1;
            void'(q.pop_front());
            q.push_back(a_wdata);
            tick();
            a_wr = 1'b0;
            n_cmp++;
            if (a2b_cnt !== 3'd4 || a_wait !== 1'b1 || a_ovf !== 1'b0 || b_rdata !== q[0]) begin
                n_err++; $display("FAIL full_rw_p%0d: got cnt %0d wait %b ovf %b head %h expected 4 1 0 %h", p, a2b_cnt, a_wait, a_ovf, b_rdata, q[0]);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (b_rdata !== q[0]) begin
                    n_err++; $display("FAIL wrap_p%0d_%0d: got %h expected %h", p, i, b_rdata, q[0]);
                end
                if (i == 3) begin
                    n_cmp++;
                    if (b_rdata !== 8'(8'h66 + p)) begin
                        n_err++; $display("FAIL last_word_p%0d: got %h expected %h", p, b_rdata, 8'(8'h66 + p));
                    end
                end
                void'(q.pop_front());
                tick();
            end
            b_rd = 1'b0;
            n_cmp++;
            if (a2b_cnt !== 3'd0) begin
                n_err++; $display("FAIL wrap_empty_p%0d: got %0d expected 0", p, a2b_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        a_rd = 1'b1; b_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_wr = 1'b1; a_wdata = 8'(i + 1);
            b_wr = 1'b1; b_wdata = 8'(8'h81 + i);
            tick();
            n_cmp++;
            if (b_rdata !== 8'(i + 1) || a_rdata !== 8'(8'h81 + i) || a2b_cnt !== 3'd1 || b2a_cnt !== 3'd1) begin
                n_err++; $display("FAIL duplex%0d: got b_rdata %h a_rdata %h cnts %0d/%0d expected %h %h 1/1",
                                  i, b_rdata, a_rdata, a2b_cnt, b2a_cnt, 8'(i + 1), 8'(8'h81 + i));
            end
        end
        a_wr = 1'b0; b_wr = 1'b0;
        tick();
        a_rd = 1'b0; b_rd = 1'b0;
        n_cmp++;
        if (a2b_cnt !== 3'd0 || b2a_cnt !== 3'd0 || a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
            n_err++; $display("FAIL duplex_end: got cnts %0d/%0d ovf %b/%b expected 0/0 0/0", a2b_cnt, b2a_cnt, a_ovf, b_ovf);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            b_wr = 1'b1; b_wdata = 8'(8'h91 + i);
            a_wr = (i < 2); a_wdata = 8'(8'hA1 + i);
            tick();
        end
        b_wr = 1'b0; a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        tick();
        a_rd = 1'b0;
        n_cmp++;
        if (b_ovf !== 1'b1 || b2a_cnt !== 3'd2 || a2b_cnt !== 3'd2 || a_rdata !== 8'h93) begin
            n_err++; $display("FAIL pre_reset: got ovf %b cnts %0d/%0d a_rdata %h expected 1 2/2 93", b_ovf, b2a_cnt, a2b_cnt, a_rdata);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({a2b_cnt, b2a_cnt, a_ovf, b_ovf, a_rvalid, b_rvalid, a_wait, b_wait} !== 12'h0 ||
            a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            n_err++; $display("FAIL mid_reset: got cnts %0d/%0d ovf %b/%b rvalid %b/%b rdata %h/%h expected all 0",
                              a2b_cnt, b2a_cnt, a_ovf, b_ovf, a_rvalid, b_rvalid, a_rdata, b_rdata);
        end
        #1;
        rst = 1'b1;
        tick();
        a_wr = 1'b1; a_wdata = 8'h5A;
        tick();
        a_wr = 1'b0;
        n_cmp++;
        if (b_rdata !== 8'h5A || a2b_cnt !== 3'd1 || b_rvalid !== 1'b1) begin
            n_err++; $display("FAIL post_reset_write: got %h cnt %0d rvalid %b expected 5a 1 1", b_rdata, a2b_cnt, b_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_full_rw();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
